// File: rtl/ahb_manager_pkg.sv
// Shared AHB manager types: transfer encodings, HSIZE constants and sequencer states.
package ahb_manager_pkg;

    localparam int KB_BOUNDARY_BITS = 10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ahb_manager_cmd_sequencer.sv
// Turns one transfer request into a stream of AHB command beats (undefined-length INCR),
// restarting as NONSEQ on every 1 KB boundary and holding while the skid buffer stalls.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no beat presented, o_cmd_trans = IDLE, request accepted
// ST_RUN  | beat presented on o_cmd_*, advances on each unstalled cycle
module ahb_manager_cmd_sequencer
    import ahb_manager_pkg::*;
#(
    parameter int AW       = 32,
    parameter int LW       = 16,
    parameter int MAX_SIZE = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic [LW-1:0] i_req_len,
    input  logic          i_req_write,
    input  logic [2:0]    i_req_size,
    output logic [AW-1:0] o_cmd_addr,
    output logic [1:0]    o_cmd_trans,
    output logic          o_cmd_write,
    output logic [2:0]    o_cmd_size,
    output logic          o_cmd_last,
    output logic          o_busy,
    output logic          o_err,
    input  logic          i_stall
);

    localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

    seq_state_t    state_q, state_d;
    htrans_t       trans_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] remaining_q;
    logic [2:0]    size_q;
    logic          write_q;
    logic          last_q;
    logic          err_q;

    logic          req_ready;
    logic          accept;
    logic          req_illegal;
    logic          advance;
    logic [AW-1:0] align_addr;
    logic [AW-1:0] step_addr;
    logic          step_boundary;

    always_comb begin
        req_ready     = (state_q == ST_IDLE) || ((state_q == ST_RUN) && last_q && !i_stall);
        accept        = i_req_valid && req_ready;
        req_illegal   = (i_req_len == '0) || (i_req_size > MAX_SIZE_L);
        advance       = (state_q == ST_RUN) && !i_stall;
        align_addr    = i_req_addr & ~((AW'(1) << i_req_size) - AW'(1));
        step_addr     = addr_q + (AW'(1) << size_q);
        // A carry out of the top bit leaves the low bits zero, so a wrap to 0 restarts too.
        step_boundary = (step_addr[KB_BOUNDARY_BITS-1:0] == '0);

        state_d = state_q;
        if (accept) begin
            state_d = req_illegal ? ST_IDLE : ST_RUN;
        end else if (advance && last_q) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            trans_q     <= HTRANS_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && req_illegal;
            if (accept && !req_illegal) begin
                trans_q     <= HTRANS_NONSEQ;
                addr_q      <= align_addr;
                write_q     <= i_req_write;
                size_q      <= i_req_size;
                remaining_q <= i_req_len - LW'(1);
                last_q      <= (i_req_len == LW'(1));
            end else if (accept || (advance && last_q)) begin
                trans_q <= HTRANS_IDLE;
                last_q  <= 1'b0;
            end else if (advance) begin
                addr_q      <= step_addr;
                remaining_q <= remaining_q - LW'(1);
                last_q      <= (remaining_q == LW'(1));
                trans_q     <= step_boundary ? HTRANS_NONSEQ : HTRANS_SEQ;
            end
        end
    end

    assign o_req_ready = req_ready;
    assign o_cmd_addr  = addr_q;
    assign o_cmd_trans = trans_q;
    assign o_cmd_write = write_q;
    assign o_cmd_size  = size_q;
    assign o_cmd_last  = last_q;
    assign o_busy      = (state_q == ST_RUN);
    assign o_err       = err_q;

endmodule

// File: tb/tb_ahb_manager_cmd_sequencer.sv
// Directed and randomized bench for the AHB command sequencer with a beat-list reference model.
module tb_ahb_manager_cmd_sequencer;
    import ahb_manager_pkg::*;

    localparam int AW = 32;
    localparam int LW = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr;
    logic [LW-1:0] i_req_len;
    logic          i_req_write;
    logic [2:0]    i_req_size;
    logic [AW-1:0] o_cmd_addr;
    logic [1:0]    o_cmd_trans;
    logic          o_cmd_write;
    logic [2:0]    o_cmd_size;
    logic          o_cmd_last;
    logic          o_busy;
    logic          o_err;
    logic          i_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic        last;
    } beat_t;

    beat_t q[$];

    ahb_manager_cmd_sequencer #(.AW(AW), .LW(LW), .MAX_SIZE(2)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_addr  (i_req_addr),
        .i_req_len   (i_req_len),
        .i_req_write (i_req_write),
        .i_req_size  (i_req_size),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_trans (o_cmd_trans),
        .o_cmd_write (o_cmd_write),
        .o_cmd_size  (o_cmd_size),
        .o_cmd_last  (o_cmd_last),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .i_stall     (i_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [15:0] l, input logic w, input logic [2:0] s);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_len   = l;
        i_req_write = w;
        i_req_size  = s;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_stall = 1'b0;
        set_req(32'h1234, 16'd3, 1'b1, HSIZE_WORD);
        step();
        step();
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy, o_err} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h trans=%0d wr=%b size=%0d last=%b busy=%b err=%b, want all zero",
                     o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy, o_err);
        end
        i_reset = 1'b0;
        i_req_valid = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_req_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ea [4];
        ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
        set_req(32'h100, 16'd4, 1'b1, HSIZE_WORD);
        for (int b = 0; b < 4; b++) begin
            step();
            i_req_valid = 1'b0;
            #1;
            checks++;
            if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write, o_busy} !==
                {ea[b], (b == 0) ? 2'd2 : 2'd3, (b == 3), 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL basic_beat%0d: got addr=%h trans=%0d last=%b wr=%b busy=%b want addr=%h last=%b",
                         b, o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write, o_busy, ea[b], (b == 3));
            end
            checks++;
            if (o_req_ready !== (b == 3)) begin
                errors++;
                $display("FAIL basic_ready%0d: got %b want %b", b, o_req_ready, (b == 3));
            end
        end
        step();
        #1;
        checks++;
        if ({o_cmd_trans, o_cmd_last, o_busy, o_req_ready, o_cmd_addr} !== {2'd0, 1'b0, 1'b0, 1'b1, 32'h10C}) begin
            errors++;
            $display("FAIL basic_idle: got trans=%0d last=%b busy=%b ready=%b addr=%h want 0/0/0/1/10c",
                     o_cmd_trans, o_cmd_last, o_busy, o_req_ready, o_cmd_addr);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] ea [4];
        logic [1:0]  et [4];
        ea = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
        et = '{2'd2, 2'd3, 2'd2, 2'd3};
        set_req(32'h3F8, 16'd4, 1'b0, HSIZE_WORD);
        for (int b = 0; b < 4; b++) begin
            step();
            i_req_valid = 1'b0;
            #1;
            checks++;
            if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write} !== {ea[b], et[b], (b == 3), 1'b0}) begin
                errors++;
                $display("FAIL boundary_beat%0d: got addr=%h trans=%0d last=%b wr=%b want addr=%h trans=%0d",
                         b, o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write, ea[b], et[b]);
            end
        end
        step();
    endtask

    task automatic test_stall();
        set_req(32'h200, 16'd3, 1'b1, HSIZE_WORD);
        step();
        i_req_valid = 1'b0;
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans} !== {32'h200, 2'd2}) begin
            errors++;
            $display("FAIL stall_beat0: got addr=%h trans=%0d want 200/2", o_cmd_addr, o_cmd_trans);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            i_stall = (c < 2);
            if (c < 2) set_req(32'h800, 16'd1, 1'b0, HSIZE_BYTE);
            else i_req_valid = 1'b0;
            #1;
            checks++;
            if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_size, o_req_ready} !== {32'h204, 2'd3, 1'b0, 3'd2, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d: got addr=%h trans=%0d last=%b size=%0d ready=%b want 204/3/0/2/0",
                         c, o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_size, o_req_ready);
            end
        end
        step();
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write} !== {32'h208, 2'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL stall_beat2: got addr=%h trans=%0d last=%b wr=%b want 208/3/1/1",
                     o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write);
        end
        step();
        #1;
        checks++;
        if ({o_cmd_trans, o_busy} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL stall_idle: got trans=%0d busy=%b want 0/0", o_cmd_trans, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        set_req(32'h40, 16'd2, 1'b0, HSIZE_HALF);
        step();
        set_req(32'h80, 16'd1, 1'b1, HSIZE_BYTE);
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_req_ready} !== {32'h40, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_beat0: got addr=%h trans=%0d last=%b ready=%b want 40/2/0/0",
                     o_cmd_addr, o_cmd_trans, o_cmd_last, o_req_ready);
        end
        step();
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_req_ready} !== {32'h42, 2'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_beat1: got addr=%h trans=%0d last=%b ready=%b want 42/3/1/1",
                     o_cmd_addr, o_cmd_trans, o_cmd_last, o_req_ready);
        end
        step();
        i_req_valid = 1'b0;
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write, o_cmd_size} !== {32'h80, 2'd2, 1'b1, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL b2b_beat2: got addr=%h trans=%0d last=%b wr=%b size=%0d want 80/2/1/1/0",
                     o_cmd_addr, o_cmd_trans, o_cmd_last, o_cmd_write, o_cmd_size);
        end
        step();
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_req(32'h10, 16'd0, 1'b0, HSIZE_WORD);
            else set_req(32'h10, 16'd2, 1'b0, 3'd3);
            step();
            i_req_valid = 1'b0;
            #1;
            checks++;
            if ({o_err, o_cmd_trans, o_busy} !== {1'b1, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL illegal_pulse%0d: got err=%b trans=%0d busy=%b want 1/0/0", k, o_err, o_cmd_trans, o_busy);
            end
            step();
            #1;
            checks++;
            if ({o_err, o_cmd_trans, o_busy} !== {1'b0, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL illegal_after%0d: got err=%b trans=%0d busy=%b want 0/0/0", k, o_err, o_cmd_trans, o_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_req(32'h1000, 16'd8, 1'b1, HSIZE_WORD);
        step();
        i_req_valid = 1'b0;
        step();
        i_reset = 1'b1;
        step();
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy, o_err, o_req_ready} !== {41'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid: got addr=%h trans=%0d wr=%b size=%0d last=%b busy=%b err=%b ready=%b",
                     o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy, o_err, o_req_ready);
        end
        i_reset = 1'b0;
        set_req(32'h20, 16'd2, 1'b0, HSIZE_WORD);
        step();
        i_req_valid = 1'b0;
        #1;
        checks++;
        if ({o_cmd_addr, o_cmd_trans, o_cmd_last} !== {32'h20, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL reset_fresh: got addr=%h trans=%0d last=%b want 20/2/0", o_cmd_addr, o_cmd_trans, o_cmd_last);
        end
        step();
        step();
    endtask

    // Model: each accepted request expands into its full beat list; the front is the beat on the bus.
    task automatic test_random();
        logic [31:0] a, tmp, align, ba;
        logic [15:0] l;
        logic [2:0]  s;
        logic        w, ready_exp, acc, illegal, err_exp;
        beat_t       bt;
        q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tmp = $urandom;
            case ($urandom_range(0, 2))
                0: a = tmp;
                1: a = {tmp[31:10], 10'h3F0} | 32'($urandom_range(0, 15));
                default: a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            endcase
            l = ($urandom_range(0, 11) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
            s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            set_req(a, l, w, s);
            i_req_valid = (cyc < 1450) && ($urandom_range(0, 2) != 0);
            i_stall = (cyc < 1450) && ($urandom_range(0, 3) == 0);
            #1;
            ready_exp = (q.size() == 0) || ((q.size() == 1) && !i_stall);
            checks++;
            if (o_req_ready !== ready_exp) begin
                errors++;
                $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, o_req_ready, ready_exp);
            end
            acc = i_req_valid && ready_exp;
            illegal = (l == 16'd0) || (s > 3'd2);
            err_exp = acc && illegal;
            if ((q.size() > 0) && !i_stall) void'(q.pop_front());
            if (acc && !illegal) begin
                align = a & ~((32'd1 << s) - 32'd1);
                for (int k = 0; k < int'(l); k++) begin
                    ba = align + 32'(k) * (32'd1 << s);
                    bt.addr  = ba;
                    bt.trans = ((k == 0) || (ba[9:0] == 10'd0)) ? 2'd2 : 2'd3;
                    bt.write = w;
                    bt.size  = s;
                    bt.last  = (k == int'(l) - 1);
                    q.push_back(bt);
                end
            end
            step();
            checks++;
            if (o_err !== err_exp) begin
                errors++;
                $display("FAIL rand_err cyc%0d: got %b want %b", cyc, o_err, err_exp);
            end
            checks++;
            if (q.size() == 0) begin
                if ({o_cmd_trans, o_cmd_last, o_busy} !== {2'd0, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL rand_idle cyc%0d: got trans=%0d last=%b busy=%b want 0/0/0",
                             cyc, o_cmd_trans, o_cmd_last, o_busy);
                end
            end else begin
                bt = q[0];
                if ({o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy} !==
                    {bt.addr, bt.trans, bt.write, bt.size, bt.last, 1'b1}) begin
                    errors++;
                    $display("FAIL rand_beat cyc%0d: got addr=%h trans=%0d wr=%b size=%0d last=%b busy=%b want addr=%h trans=%0d wr=%b size=%0d last=%b",
                             cyc, o_cmd_addr, o_cmd_trans, o_cmd_write, o_cmd_size, o_cmd_last, o_busy,
                             bt.addr, bt.trans, bt.write, bt.size, bt.last);
                end
            end
        end
        i_req_valid = 1'b0;
        i_stall = 1'b0;
    endtask

    initial begin
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_len   = '0;
        i_req_write = 1'b0;
        i_req_size  = '0;
        i_stall     = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
